// File: rtl/permute_map.sv
// DES Initial Permutation engine: captures a 64-bit block on set and builds
// the permuted result one output byte per clock, publishing all 64 bits at once.
module permute_map (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic [0:63] data_in,
    output logic        status,
    output logic [0:63] data_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [0:63] captured_r, captured_s;
    logic [0:63] scratch_r, scratch_s;
    logic [0:63] data_out_r, data_out_s;
    logic        status_r, status_s;
    logic [0:7]  byte_s;

    // Output byte k of the IP table: row k starts at 57+2k (k<4) or 56+2(k-4),
    // and each further column steps back by 8 source bits.
    function automatic logic [0:7] perm_byte(input logic [0:63] blk,
                                             input logic [2:0]  k);
        logic [5:0] base;
        logic [5:0] src;
        logic [0:7] res;
        base = k[2] ? 6'd56 : 6'd57;
        base = base + {2'b00, k[1:0], 1'b0};
        res  = 8'h00;
        for (int c = 0; c < 8; c++) begin
            src    = base - {c[2:0], 3'b000};
            res[c] = blk[src];
        end
        return res;
    endfunction

    // Next-state and datapath: set restarts from any state; RUN fills one byte per edge.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        captured_s = captured_r;
        scratch_s  = scratch_r;
        data_out_s = data_out_r;
        status_s   = status_r;
        byte_s     = perm_byte(captured_r, cnt_r);
        if (set) begin
            captured_s = data_in;
            scratch_s  = 64'h0;
            cnt_s      = 3'd0;
            state_s    = RUN;
            status_s   = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    for (int c = 0; c < 8; c++) begin
                        scratch_s[{cnt_r, c[2:0]}] = byte_s[c];
                    end
                    cnt_s = cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        // Last byte goes straight into data_out on the same edge.
                        data_out_s = scratch_s;
                        status_s   = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        state_s = RUN;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            captured_r <= 64'h0;
            scratch_r  <= 64'h0;
            data_out_r <= 64'h0;
            status_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            captured_r <= captured_s;
            scratch_r  <= scratch_s;
            data_out_r <= data_out_s;
            status_r   <= status_s;
        end
    end

    assign data_out = data_out_r;
    assign status   = status_r;

endmodule

// File: tb/tb_permute_map.sv
// Directed and random bench for permute_map against an index-table model of DES IP.
module tb_permute_map;

    logic        clk;
    logic        rst_n;
    logic        set;
    logic [0:63] data_in;
    logic        status;
    logic [0:63] data_out;

    int tests_run;
    int tests_failed;

    permute_map dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set),
        .data_in  (data_in),
        .status   (status),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: output bit i (MSB = 0) takes input bit S(i) from the rule table.
    function automatic logic [63:0] ref_perm(input logic [63:0] v);
        logic [63:0] r;
        int row, col, s;
        r = 64'h0;
        for (int i = 0; i < 64; i++) begin
            row = i / 8;
            col = i % 8;
            if (row < 4) s = 57 + 2 * row - 8 * col;
            else         s = 56 + 2 * (row - 4) - 8 * col;
            r[63 - i] = v[63 - s];
        end
        return r;
    endfunction

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pulse set for one edge, then check status low for 7 edges and the result on the 8th.
    task automatic run_job(input string tag, input logic [63:0] v, input logic [63:0] exp);
        logic [63:0] prev;
        prev = data_out;
        @(negedge clk);
        set = 1'b1;
        data_in = v;
        @(posedge clk); #1;
        chk1({tag, "_set_status"}, status, 1'b0);
        chk64({tag, "_set_hold"}, data_out, prev);
        @(negedge clk);
        set = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            if (e < 8) begin
                chk1({tag, "_busy_status"}, status, 1'b0);
                chk64({tag, "_busy_hold"}, data_out, prev);
            end else begin
                chk1({tag, "_done_status"}, status, 1'b1);
                chk64({tag, "_done_data"}, data_out, exp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        tests_run    = 0;
        tests_failed = 0;
        rst_n   = 1'b0;
        set     = 1'b0;
        data_in = 64'h0;

        // Reset, with set asserted to show reset priority.
        @(negedge clk); set = 1'b1; data_in = 64'hffffffffffffffff;
        @(negedge clk); set = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk1("reset_status", status, 1'b0);
            chk64("reset_data", data_out, 64'h0);
        end

        run_job("known", 64'h0123456789abcdef, 64'hcc00ccfff0aaf0aa);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk1("hold_status", status, 1'b1);
            chk64("hold_data", data_out, 64'hcc00ccfff0aaf0aa);
        end
        run_job("bit57", 64'h0000000000000040, 64'h8000000000000000);
        run_job("bit0", 64'h8000000000000000, 64'h0000000001000000);
        run_job("zero", 64'h0, 64'h0);
        run_job("ones", 64'hffffffffffffffff, 64'hffffffffffffffff);

        // Restart three edges into a job; the first result must never appear.
        @(negedge clk); set = 1'b1; data_in = 64'h0123456789abcdef;
        @(negedge clk); set = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk1("restart_a_status", status, 1'b0);
        end
        run_job("restart_b", 64'hffffffffffffffff, 64'hffffffffffffffff);

        // Held set: completion counts from the last set edge.
        @(negedge clk); set = 1'b1; data_in = 64'h0123456789abcdef;
        @(negedge clk); data_in = 64'h1111111111111111;
        @(negedge clk); data_in = 64'h8000000000000000;
        @(negedge clk); set = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            chk1("held_status", status, (e == 8) ? 1'b1 : 1'b0);
        end
        chk64("held_data", data_out, 64'h0000000001000000);

        // Reset mid-run aborts without any later completion.
        @(negedge clk); set = 1'b1; data_in = 64'h0123456789abcdef;
        @(negedge clk); set = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk1("midrst_status", status, 1'b0);
        chk64("midrst_data", data_out, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk1("midrst_idle_status", status, 1'b0);
            chk64("midrst_idle_data", data_out, 64'h0);
        end

        // Random blocks against the reference model.
        for (int n = 0; n < 24; n++) begin
            v = {$urandom, $urandom};
            run_job("random", v, ref_perm(v));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/permute_map.md
Name: permute_map

Overview:
- Fixed 64-bit bit-permutation engine using the DES Initial Permutation (IP) table.
- Captures a 64-bit block on a `set` strobe and builds the permuted result one output byte per clock.
- Presents the full result on `data_out` and raises `status` when the result is complete.
- Sits in the encrypter datapath as the block-scrambling stage in front of the round logic.

Parameters:
- none. Width is fixed at 64 bits and the permutation table is hard-coded.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- set  input  1  start strobe; samples `data_in` and starts a permutation.
- data_in  input  64 [0:63]  input block; bit 0 is the MSB.
- status  output  1  done flag; 1 = `data_out` holds a valid, complete result.
- data_out  output  64 [0:63]  permuted block; bit 0 is the MSB.

Behaviour:
- Bit numbering: index 0 is the MSB for both `data_in` and `data_out`.
- Permutation rule: `data_out[i] = captured[S(i)]`, with r = i/8 and c = i%8.
  - r < 4: S(i) = 57 + 2r − 8c.
  - r ≥ 4: S(i) = 56 + 2(r−4) − 8c.
  - This is the DES IP table 58,50,42,…,7 converted to 0-based indices.
- Reset (rst_n=0 at a rising edge):
  - `data_out` = 64'h0, `status` = 0.
  - Internal capture register = 0, byte counter = 0, busy = 0.
  - Reset has priority over `set`.
  - Reset during a permutation aborts it; no partial result is ever output.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, 3-bit counter k = 0..7).
- Start: at an edge with rst_n=1 and set=1, from either state:
  - capture `data_in`, clear the scratch result, set k=0, enter RUN, drive `status` to 0.
  - `data_out` keeps its previous value.
  - `set` asserted during RUN restarts with the new `data_in`; the old job is discarded.
- RUN with set=0, each edge:
  - compute output byte k (output bits 8k..8k+1 through 8k+7) from the captured block into the scratch register;
  - increment k.
- Completion, on the edge that writes byte 7:
  - `data_out` <= full scratch result, with byte 7 included;
  - `status` <= 1; return to IDLE.
- Latency: `status` rises on the 8th rising edge after the edge that sampled set=1.
  - `data_out` and `status` change together on that edge.
- Holding: `status` stays 1 and `data_out` stays stable until the next set or reset.
- Held set: if `set` is held high for several cycles, every such edge restarts the job. Completion is 8 edges after the last edge with set=1.
- Combinational paths: none from inputs to outputs; both outputs are registered.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 with set=0 → `data_out` = 64'h0, `status` = 0, both unchanged indefinitely.
- Known vector: `data_in` = 64'h0123456789abcdef, set=1 for one cycle → `status` stays 0 for 7 edges, rises on the 8th edge, and `data_out` = 64'hcc00ccfff0aaf0aa.
- Single-bit mapping:
  - `data_in` = 64'h0000000000000040 → `data_out` = 64'h8000000000000000.
  - `data_in` = 64'h8000000000000000 → `data_out` = 64'h0000000001000000.
- Edge values: `data_in` = 64'h0 → 64'h0; `data_in` = 64'hffffffffffffffff → 64'hffffffffffffffff; each with `status` rising 8 edges after set.
- Restart mid-run: start with 64'h0123456789abcdef, then pulse set again 3 cycles later with 64'hffffffffffffffff → `status` falls to 0 and does not rise early. It rises 8 edges after the second set with `data_out` = 64'hffffffffffffffff; the first result is never presented.
- Reset mid-run: start a job, then assert rst_n=0 after 4 cycles → `data_out` = 0 and `status` = 0, with no later completion until a new set.
